// File: rtl/jtag_mem_arbiter_if.sv
// Request/response bundle of the JTAG memory arbiter and its
// downstream jtag_memory_interface port.
interface jtag_mem_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 2
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ-1:0]            req_write;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
    logic [NUM_REQ-1:0]            resp_valid;
    logic [DATA_WIDTH-1:0]         resp_rdata;
    logic                          resp_error;
    logic                          mem_enable;
    logic                          mem_write;
    logic [ADDR_WIDTH-1:0]         mem_address;
    logic [DATA_WIDTH-1:0]         mem_write_data;
    logic [DATA_WIDTH-1:0]         mem_read_data;
    logic                          mem_ready;
    logic                          mem_error;
    logic                          busy;
    logic [ID_WIDTH-1:0]           grant_id;
    logic [15:0]                   err_count;

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        input  mem_read_data, mem_ready, mem_error,
        output req_ready, resp_valid, resp_rdata, resp_error,
        output mem_enable, mem_write, mem_address, mem_write_data,
        output busy, grant_id, err_count
    );

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        output mem_read_data, mem_ready, mem_error,
        input  req_ready, resp_valid, resp_rdata, resp_error,
        input  mem_enable, mem_write, mem_address, mem_write_data,
        input  busy, grant_id, err_count
    );
endinterface

// File: rtl/jtag_mem_arbiter.sv
// Round-robin arbiter and sequencer sharing one JTAG memory port
// among NUM_REQ requesters, with a per-transaction timeout.
module jtag_mem_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int ID_WIDTH       = 2
) (
    input logic               clk,
    input logic               reset,
    jtag_mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, RESPOND, RELEASE} state_t;

    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [ID_WIDTH-1:0] LAST_ID = ID_WIDTH'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);
    localparam logic [DATA_WIDTH-1:0] ABORT_DATA = DATA_WIDTH'(32'hDEADBEEF);

    state_t              state;
    logic [ID_WIDTH-1:0] rr_ptr;
    logic [ID_WIDTH-1:0] winner;
    logic                found;
    logic [TW-1:0]       tcnt;
    logic [NUM_REQ-1:0]  grant_hot;

    // First valid requester scanning upward from rr_ptr, wrapping.
    always_comb begin
        int idx;
        idx    = 0;
        winner = '0;
        found  = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (!found && bus.req_valid[idx]) begin
                found  = 1'b1;
                winner = ID_WIDTH'(idx);
            end
        end
    end

    assign bus.req_ready = (state == IDLE && found) ? (ONE << winner) : '0;
    assign grant_hot     = ONE << bus.grant_id;

    always_ff @(posedge clk) begin
        if (reset) begin
            state              <= IDLE;
            rr_ptr             <= '0;
            tcnt               <= '0;
            bus.busy           <= 1'b0;
            bus.grant_id       <= '0;
            bus.mem_enable     <= 1'b0;
            bus.mem_write      <= 1'b0;
            bus.mem_address    <= '0;
            bus.mem_write_data <= '0;
            bus.resp_valid     <= '0;
            bus.resp_rdata     <= '0;
            bus.resp_error     <= 1'b0;
            bus.err_count      <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (found) begin
                        bus.mem_write      <= bus.req_write[winner];
                        bus.mem_address    <= bus.req_addr[int'(winner)*ADDR_WIDTH +: ADDR_WIDTH];
                        bus.mem_write_data <= bus.req_wdata[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
                        bus.mem_enable     <= 1'b1;
                        bus.grant_id       <= winner;
                        rr_ptr             <= (winner == LAST_ID) ? '0 : winner + 1'b1;
                        tcnt               <= '0;
                        bus.busy           <= 1'b1;
                        state              <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (bus.mem_ready) begin
                        bus.resp_rdata <= bus.mem_read_data;
                        bus.resp_error <= bus.mem_error;
                        bus.mem_enable <= 1'b0;
                        bus.resp_valid <= grant_hot;
                        state          <= RESPOND;
                    end else if (tcnt == T_LAST) begin
                        bus.resp_rdata <= ABORT_DATA;
                        bus.resp_error <= 1'b1;
                        bus.mem_enable <= 1'b0;
                        bus.resp_valid <= grant_hot;
                        state          <= RESPOND;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                RESPOND: begin
                    bus.resp_valid <= '0;
                    if (bus.resp_error && bus.err_count != 16'hFFFF)
                        bus.err_count <= bus.err_count + 16'd1;
                    tcnt  <= '0;
                    state <= RELEASE;
                end
                RELEASE: begin
                    // Wait out a lingering ready so it cannot finish the next access.
                    if (!bus.mem_ready || tcnt == T_LAST) begin
                        tcnt     <= '0;
                        bus.busy <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
